// File: rtl/dct_pkg.sv
// Shared constants and helpers for the dct8_pipe butterfly engine.
// Multiplier constants are stored as c*1e5 and quantised to COEF_FRAC bits.
package dct_pkg;

   localparam int unsigned DCT_N = 8;

   localparam int C1_E5 = 70711;   // cos(pi/4)
   localparam int C2_E5 = 38268;   // sin(pi/8)
   localparam int C3_E5 = 54120;
   localparam int C4_E5 = 130656;

   // Quantised toward zero; yields 181/97/138/334 at 8 fractional bits.
   function automatic int coef_q(int c_e5, int frac);
      longint t;
      t = longint'(c_e5) << frac;
      return int'(t / 100000);
   endfunction

   localparam int M1 = coef_q(C1_E5, 8);
   localparam int M2 = coef_q(C2_E5, 8);
   localparam int M3 = coef_q(C3_E5, 8);
   localparam int M4 = coef_q(C4_E5, 8);

   function automatic longint sext(logic [63:0] v, int w);
      logic signed [63:0] t;
      t = signed'(v << (64 - w));
      return t >>> (64 - w);
   endfunction

   function automatic longint sat_val(longint v, int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic sat_hit(longint v, int w);
      longint hi;
      longint lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      return (v > hi) || (v < lo);
   endfunction

endpackage

// File: rtl/dct_cmul.sv
// Signed constant multiply followed by an arithmetic right shift.
// DCT_ROUND_EN adds half an LSB before the shift (round half-up); otherwise floor.
module dct_cmul #(
   parameter int W    = 14,
   parameter int FRAC = 8,
   parameter int COEF = 181
) (
   input  logic signed [W-1:0] a,
   output logic signed [W-1:0] y
);

   localparam int PW = W + FRAC + 2;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_r;

   assign prod = PW'(a) * PW'(COEF);

`ifdef DCT_ROUND_EN
   assign prod_r = prod + PW'(1 << (FRAC - 1));
`else
   assign prod_r = prod;
`endif

   assign y = W'(prod_r >>> FRAC);

endmodule

// File: rtl/dct8_pipe.sv
// 4-stage pipelined 8-point DCT-II with valid/ready backpressure and output saturation.
// DCT_ROUND_EN selects round-half-up in the constant multipliers.
module dct8_pipe
   import dct_pkg::*;
#(
   parameter int IN_W      = 10,
   parameter int OUT_W     = 12,
   parameter int COEF_FRAC = 8,
   parameter int INT_W     = IN_W + 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*IN_W-1:0]    in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*OUT_W-1:0]   out_data,
   output logic                 out_last,
   output logic [7:0]           out_sat
);

   if (INT_W < IN_W + 4) begin : g_bad_int_w
      $error("INT_W must be at least IN_W+4");
   end

   localparam int K1 = coef_q(C1_E5, COEF_FRAC);
   localparam int K2 = coef_q(C2_E5, COEF_FRAC);
   localparam int K3 = coef_q(C3_E5, COEF_FRAC);
   localparam int K4 = coef_q(C4_E5, COEF_FRAC);

   logic signed [INT_W-1:0] a_d [DCT_N];
   logic signed [INT_W-1:0] a_q [DCT_N];
   logic signed [INT_W-1:0] b   [DCT_N];
   logic signed [INT_W-1:0] c_d [DCT_N];
   logic signed [INT_W-1:0] c_q [DCT_N];
   logic signed [INT_W-1:0] d   [9];
   logic signed [INT_W-1:0] e_d [9];
   logic signed [INT_W-1:0] e_q [9];
   logic signed [INT_W-1:0] f   [DCT_N];
   logic signed [INT_W-1:0] y   [DCT_N];
   logic signed [INT_W-1:0] m_e2, m_e3, m_e4, m_e6, m_e7;

   logic [8*OUT_W-1:0] out_data_d;
   logic [7:0]         out_sat_d;
   logic               v1_q, v2_q, v3_q;
   logic               l1_q, l2_q, l3_q;
   logic               adv;

   // Single global stall: everything moves only when the output slot frees.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_comb begin
      for (int i = 0; i < DCT_N; i++) begin
         a_d[i] = INT_W'(sext(64'(in_data[i*IN_W +: IN_W]), IN_W));
      end
   end

   always_comb begin
      b[0] = a_q[0] + a_q[7];
      b[1] = a_q[1] + a_q[6];
      b[2] = a_q[2] - a_q[4];
      b[3] = a_q[1] - a_q[6];
      b[4] = a_q[2] + a_q[5];
      b[5] = a_q[3] + a_q[4];
      b[6] = a_q[2] - a_q[5];
      b[7] = a_q[0] - a_q[7];
      c_d[0] = b[0] + b[5];
      c_d[1] = b[1] - b[4];
      c_d[2] = b[2] + b[6];
      c_d[3] = b[1] + b[4];
      c_d[4] = b[0] - b[5];
      c_d[5] = b[3] + b[7];
      c_d[6] = b[3] + b[6];
      c_d[7] = b[7];
   end

   always_comb begin
      d[0] = c_q[0] + c_q[3];
      d[1] = c_q[0] - c_q[3];
      d[2] = c_q[2];
      d[3] = c_q[1] + c_q[4];
      d[4] = c_q[2] - c_q[5];
      d[5] = c_q[4];
      d[6] = c_q[5];
      d[7] = c_q[6];
      d[8] = c_q[7];
   end

   dct_cmul #(.W(INT_W), .FRAC(COEF_FRAC), .COEF(K3)) u_mul_e2 (.a(d[2]), .y(m_e2));
   dct_cmul #(.W(INT_W), .FRAC(COEF_FRAC), .COEF(K1)) u_mul_e3 (.a(d[7]), .y(m_e3));
   dct_cmul #(.W(INT_W), .FRAC(COEF_FRAC), .COEF(K4)) u_mul_e4 (.a(d[6]), .y(m_e4));
   dct_cmul #(.W(INT_W), .FRAC(COEF_FRAC), .COEF(K1)) u_mul_e6 (.a(d[3]), .y(m_e6));
   dct_cmul #(.W(INT_W), .FRAC(COEF_FRAC), .COEF(K2)) u_mul_e7 (.a(d[4]), .y(m_e7));

   always_comb begin
      e_d[0] = d[0];
      e_d[1] = d[1];
      e_d[2] = m_e2;
      e_d[3] = m_e3;
      e_d[4] = m_e4;
      e_d[5] = d[5];
      e_d[6] = m_e6;
      e_d[7] = m_e7;
      e_d[8] = d[8];
   end

   always_comb begin
      f[0] = '0;
      f[1] = '0;
      f[2] = e_q[5] + e_q[6];
      f[3] = e_q[5] - e_q[6];
      f[4] = e_q[3] + e_q[8];
      f[5] = e_q[8] - e_q[3];
      f[6] = e_q[2] + e_q[7];
      f[7] = e_q[4] + e_q[7];
      y[0] = e_q[0];
      y[1] = f[4] + f[7];
      y[2] = f[2];
      y[3] = f[5] - f[6];
      y[4] = e_q[1];
      y[5] = f[5] + f[6];
      y[6] = f[3];
      y[7] = f[4] - f[7];
      out_data_d = '0;
      out_sat_d  = '0;
      for (int k = 0; k < DCT_N; k++) begin
         out_data_d[k*OUT_W +: OUT_W] = OUT_W'(sat_val(longint'(y[k]), OUT_W));
         out_sat_d[k]                 = sat_hit(longint'(y[k]), OUT_W);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         l1_q      <= 1'b0;
         l2_q      <= 1'b0;
         l3_q      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
         for (int i = 0; i < DCT_N; i++) begin
            a_q[i] <= '0;
            c_q[i] <= '0;
         end
         for (int i = 0; i < 9; i++) e_q[i] <= '0;
      end else if (adv) begin
         v1_q      <= in_valid;
         v2_q      <= v1_q;
         v3_q      <= v2_q;
         out_valid <= v3_q;
         l1_q      <= in_last;
         l2_q      <= l1_q;
         l3_q      <= l2_q;
         out_last  <= l3_q;
         out_data  <= out_data_d;
         out_sat   <= out_sat_d;
         a_q       <= a_d;
         c_q       <= c_d;
         e_q       <= e_d;
      end
   end

endmodule

// File: tb/tb_dct8_pipe.sv
// Scoreboard bench for dct8_pipe: directed vectors plus an independent flow-graph model.
module tb_dct8_pipe;

   localparam int IN_W  = 10;
   localparam int OUT_W = 12;

   typedef struct {
      logic [95:0] data;
      logic [7:0]  sat;
      logic        last;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [95:0] out_data;
   logic        out_last;
   logic [7:0]  out_sat;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   ready_mode = 1'b0;
   int   rdy_idx  = 0;

   always #5 clk = ~clk;

   dct8_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(8), .INT_W(IN_W + 4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .out_sat  (out_sat)
   );

   task automatic check_eq(string tag, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int wrap14(int v);
      return (v <<< 18) >>> 18;
   endfunction

   function automatic int mul(int v, int k);
      int p;
      p = v * k;
`ifdef DCT_ROUND_EN
      p = p + 128;
`endif
      return wrap14(p >>> 8);
   endfunction

   function automatic logic [79:0] pack_x(int x[8]);
      logic [79:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*10 +: 10] = 10'(x[i]);
      return r;
   endfunction

   function automatic logic [95:0] pack_y(int v[8]);
      logic [95:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*12 +: 12] = 12'(v[i]);
      return r;
   endfunction

   task automatic model(input int x[8], output logic [95:0] data, output logic [7:0] sat);
      int b[8], c[8], d[9], e[9], yy[8], ys[8];
      b[0] = wrap14(x[0] + x[7]); b[1] = wrap14(x[1] + x[6]);
      b[2] = wrap14(x[2] - x[4]); b[3] = wrap14(x[1] - x[6]);
      b[4] = wrap14(x[2] + x[5]); b[5] = wrap14(x[3] + x[4]);
      b[6] = wrap14(x[2] - x[5]); b[7] = wrap14(x[0] - x[7]);
      c[0] = wrap14(b[0] + b[5]); c[1] = wrap14(b[1] - b[4]);
      c[2] = wrap14(b[2] + b[6]); c[3] = wrap14(b[1] + b[4]);
      c[4] = wrap14(b[0] - b[5]); c[5] = wrap14(b[3] + b[7]);
      c[6] = wrap14(b[3] + b[6]); c[7] = b[7];
      d[0] = wrap14(c[0] + c[3]); d[1] = wrap14(c[0] - c[3]); d[2] = c[2];
      d[3] = wrap14(c[1] + c[4]); d[4] = wrap14(c[2] - c[5]);
      d[5] = c[4]; d[6] = c[5]; d[7] = c[6]; d[8] = c[7];
      e[0] = d[0]; e[1] = d[1]; e[5] = d[5]; e[8] = d[8];
      e[2] = mul(d[2], 138); e[3] = mul(d[7], 181); e[4] = mul(d[6], 334);
      e[6] = mul(d[3], 181); e[7] = mul(d[4], 97);
      yy[0] = e[0];
      yy[1] = wrap14(wrap14(e[3] + e[8]) + wrap14(e[4] + e[7]));
      yy[2] = wrap14(e[5] + e[6]);
      yy[3] = wrap14(wrap14(e[8] - e[3]) - wrap14(e[2] + e[7]));
      yy[4] = e[1];
      yy[5] = wrap14(wrap14(e[8] - e[3]) + wrap14(e[2] + e[7]));
      yy[6] = wrap14(e[5] - e[6]);
      yy[7] = wrap14(wrap14(e[3] + e[8]) - wrap14(e[4] + e[7]));
      sat = '0;
      for (int k = 0; k < 8; k++) begin
         ys[k] = yy[k];
         if (yy[k] > 2047)  begin ys[k] = 2047;  sat[k] = 1'b1; end
         if (yy[k] < -2048) begin ys[k] = -2048; sat[k] = 1'b1; end
      end
      data = pack_y(ys);
   endtask

   task automatic send(input logic [79:0] d, input logic last, input logic [95:0] ed,
                       input logic [7:0] es, input bit chk);
      bit acc;
      int guard;
      exp_t e;
      acc   = 1'b0;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = in_ready && rst_n;
         guard++;
         if (acc) begin
            e.data = ed; e.sat = es; e.last = last; e.acc_cyc = cyc; e.chk_lat = chk;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("accept_timeout", 128'(acc), 128'(1));
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_model(input int x[8], input logic last, input bit chk);
      logic [95:0] ed;
      logic [7:0]  es;
      model(x, ed, es);
      send(pack_x(x), last, ed, es, chk);
   endtask

   task automatic send_fixed(input int x[8], input int yv[8], input logic [7:0] es);
      send(pack_x(x), 1'b0, pack_y(yv), es, 1'b1);
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(posedge clk);
         guard++;
      end
      if (sb.size() != 0) check_eq("drain_timeout", 128'(sb.size()), 128'(0));
      #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode) begin
            out_ready = (rdy_idx % 3 == 0);
            rdy_idx++;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check_eq("in_ready", 128'(in_ready), 128'(!(out_valid && !out_ready)));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_eq("stale_beat", 128'(out_valid), 128'(0));
            end else begin
               mon_e = sb.pop_front();
               check_eq("out_data", 128'(out_data), 128'(mon_e.data));
               check_eq("out_sat", 128'(out_sat), 128'(mon_e.sat));
               check_eq("out_last", 128'(out_last), 128'(mon_e.last));
               if (mon_e.chk_lat) check_eq("latency", 128'(cyc - mon_e.acc_cyc), 128'(4));
            end
         end
      end
   end

   initial begin
      int x[8];
      int yv[8];
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 128'(out_valid), 128'(0));
      check_eq("rst_out_data", 128'(out_data), 128'(0));
      check_eq("rst_out_last", 128'(out_last), 128'(0));
      check_eq("rst_out_sat", 128'(out_sat), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Constant input: only the DC term survives.
      foreach (x[i]) x[i] = 10;
      yv = '{80, 0, 0, 0, 0, 0, 0, 0};
      send_fixed(x, yv, 8'h00);
      wait_drain();

      // Alternating +/-100 exercises the odd-output multipliers.
      foreach (x[i]) x[i] = (i % 2 == 0) ? 100 : -100;
`ifdef DCT_ROUND_EN
      yv = '{0, 276, 0, 16, 0, 384, 0, 124};
`else
      yv = '{0, 275, 0, 18, 0, 382, 0, 125};
`endif
      send_fixed(x, yv, 8'h00);
      wait_drain();

      // Full-scale inputs saturate y0 at both rails.
      foreach (x[i]) x[i] = 511;
      yv = '{2047, 0, 0, 0, 0, 0, 0, 0};
      send_fixed(x, yv, 8'h01);
      foreach (x[i]) x[i] = -512;
      yv = '{-2048, 0, 0, 0, 0, 0, 0, 0};
      send_fixed(x, yv, 8'h01);
      wait_drain();

      // Back-to-back random beats at full throughput.
      for (int n = 0; n < 16; n++) begin
         foreach (x[i]) x[i] = (n < 4) ? ((($urandom_range(0, 1) == 0) ? -512 : 511))
                                       : (int'($urandom_range(0, 1023)) - 512);
         send_model(x, 1'b0, 1'b1);
      end
      wait_drain();

      // Eight-beat block under backpressure; last tag on the final beat only.
      ready_mode = 1'b1;
      for (int n = 0; n < 8; n++) begin
         foreach (x[i]) x[i] = int'($urandom_range(0, 1023)) - 512;
         send_model(x, (n == 7), 1'b0);
      end
      wait_drain();
      ready_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Mid-stream reset: three beats in flight must vanish.
      for (int n = 0; n < 3; n++) begin
         foreach (x[i]) x[i] = 50 * (n + 1) - 7 * i;
         send_model(x, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_valid", 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      foreach (x[i]) x[i] = 3 * i - 9;
      send_model(x, 1'b1, 1'b1);
      wait_drain();
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
